// File: rtl/addr_dec_pkg.sv
// +--------------------------------------------------------------------------+
// | addr_dec_pkg : shared types and reset map for the addr_dec_ws decoder    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package addr_dec_pkg;

    // Table fields are stored at a fixed maximum width; narrower configs zero-extend.
    localparam int ADDR_MAX_W      = 32;
    localparam int WS_MAX_W        = 16;
    localparam int RST_NUM_REGIONS = 4;
    localparam int RST_MASK_BITS   = 6;

    localparam logic [ADDR_MAX_W-1:0] RST_BASE_0 = 32'h0000_0400;
    localparam logic [ADDR_MAX_W-1:0] RST_BASE_1 = 32'h0000_0800;
    localparam logic [ADDR_MAX_W-1:0] RST_BASE_2 = 32'h0000_0C00;
    localparam logic [ADDR_MAX_W-1:0] RST_BASE_3 = 32'h0000_7C00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_MAX_W-1:0] base;
        logic [ADDR_MAX_W-1:0] mask;
        logic [WS_MAX_W-1:0]   ws;
        logic                  en;
    } region_t;

    function automatic region_t rst_region(input int idx, input int aw);
        region_t r;
        r = '0;
        if (idx < RST_NUM_REGIONS) begin
            case (idx)
                0:       r.base = RST_BASE_0;
                1:       r.base = RST_BASE_1;
                2:       r.base = RST_BASE_2;
                default: r.base = RST_BASE_3;
            endcase
            for (int b = 0; b < ADDR_MAX_W; b++) begin
                if ((b >= aw - RST_MASK_BITS) && (b < aw)) begin
                    r.mask[b] = 1'b1;
                end
            end
            r.en = 1'b1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/addr_region_match.sv
// +--------------------------------------------------------------------------+
// | addr_region_match : masked base compare for one decoder region           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module addr_region_match
    import addr_dec_pkg::*;
(
    input  logic [ADDR_MAX_W-1:0] i_addr,
    input  logic [ADDR_MAX_W-1:0] i_base,
    input  logic [ADDR_MAX_W-1:0] i_mask,
    input  logic                  i_en,
    output logic                  o_hit
);

    assign o_hit = i_en && ((i_addr & i_mask) == (i_base & i_mask));

endmodule

`default_nettype wire

// File: rtl/addr_dec_ws.sv
// +--------------------------------------------------------------------------+
// | addr_dec_ws : programmable address decoder with per-region wait states   |
// | Optional: ADDR_DEC_ERR_RESP_EN pulses err with ready on unmapped access. |
// | Supports ADDR_W up to 32 and WS_W up to 16.                              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module addr_dec_ws
    import addr_dec_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int NUM_CS = 4,
    parameter int WS_W   = 4
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              req,
    input  logic [ADDR_W-1:0]                                 addr,
    output logic [NUM_CS-1:0]                                 cs,
    output logic                                              ready,
    output logic                                              err,
    output logic                                              busy,
    input  logic                                              cfg_we,
    input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0]    cfg_idx,
    input  logic [ADDR_W-1:0]                                 cfg_base,
    input  logic [ADDR_W-1:0]                                 cfg_mask,
    input  logic [WS_W-1:0]                                   cfg_ws,
    input  logic                                              cfg_en
);

    localparam int IDX_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    state_e                r_state;
    logic [NUM_CS-1:0]     r_cs;
    logic [WS_MAX_W-1:0]   r_cnt;
    region_t               r_table [NUM_CS];

    logic [ADDR_MAX_W-1:0] w_addr_ext;
    logic [NUM_CS-1:0]     w_hit;
    logic [NUM_CS-1:0]     w_sel;
    logic [WS_MAX_W-1:0]   w_sel_ws;
    logic                  w_found;
    region_t               w_cfg_entry;

    assign w_addr_ext       = ADDR_MAX_W'(addr);
    assign w_cfg_entry.base = ADDR_MAX_W'(cfg_base);
    assign w_cfg_entry.mask = ADDR_MAX_W'(cfg_mask);
    assign w_cfg_entry.ws   = WS_MAX_W'(cfg_ws);
    assign w_cfg_entry.en   = cfg_en;

    // An index outside 0..NUM_CS-1 matches no entry and is dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CS; i++) begin
            if (!rst_n) begin
                r_table[i] <= rst_region(i, ADDR_W);
            end else if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                r_table[i] <= w_cfg_entry;
            end
        end
    end

    for (genvar g = 0; g < NUM_CS; g++) begin : g_match
        addr_region_match u_match (
            .i_addr (w_addr_ext),
            .i_base (r_table[g].base),
            .i_mask (r_table[g].mask),
            .i_en   (r_table[g].en),
            .o_hit  (w_hit[g])
        );
    end

    always_comb begin
        w_sel    = '0;
        w_sel_ws = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (w_hit[i] && !w_found) begin
                w_found  = 1'b1;
                w_sel[i] = 1'b1;
                w_sel_ws = r_table[i].ws;
            end
        end
    end

    // Decode sees the table as it was before any same-edge cfg write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cs    <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_state <= ST_ACCESS;
                        r_cs    <= w_sel;
                        r_cnt   <= w_sel_ws;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - WS_MAX_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_cs    <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cs    <= '0;
                end
            endcase
        end
    end

    assign cs    = r_cs;
    assign ready = (r_state == ST_DONE);
    assign busy  = (r_state != ST_IDLE);

`ifdef ADDR_DEC_ERR_RESP_EN
    logic r_unmapped;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_unmapped <= 1'b0;
        end else if ((r_state == ST_IDLE) && req) begin
            r_unmapped <= ~|w_sel;
        end
    end

    assign err = ready && r_unmapped;
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_addr_dec_ws.sv
// +--------------------------------------------------------------------------+
// | tb_addr_dec_ws : directed scoreboard bench for addr_dec_ws               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_addr_dec_ws;

`ifdef ADDR_DEC_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [15:0] addr = '0;
    logic [3:0]  cs;
    logic        ready;
    logic        err;
    logic        busy;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [15:0] cfg_base = '0;
    logic [15:0] cfg_mask = '0;
    logic [3:0]  cfg_ws = '0;
    logic        cfg_en = 1'b0;

    typedef struct {
        logic [3:0] cs;
        logic       err;
        int         rdy_cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    addr_dec_ws dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .addr     (addr),
        .cs       (cs),
        .ready    (ready),
        .err      (err),
        .busy     (busy),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_base (cfg_base),
        .cfg_mask (cfg_mask),
        .cfg_ws   (cfg_ws),
        .cfg_en   (cfg_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expected response per ready strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && q.size() != 0) chk("cs_during_access", {28'd0, cs}, {28'd0, q[0].cs});
            if (!busy) chk("cs_idle", {28'd0, cs}, 32'd0);
            if (ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ready_cycle", cyc, e.rdy_cyc);
                    chk("err_at_ready", {31'd0, err}, {31'd0, e.err});
                end
            end else begin
                chk("err_without_ready", {31'd0, err}, 32'd0);
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [3:0] c, input int ws);
        exp_t e;
        req  = 1'b1;
        addr = a;
        e.cs = c;
        e.err = ERR_EN && (c == 4'd0);
        e.rdy_cyc = cyc + 2 + ws;
        q.push_back(e);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        if (!seen) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic access(input logic [15:0] a, input logic [3:0] c, input int ws);
        @(posedge clk);
        #1 issue(a, c, ws);
        wait_done();
    endtask

    task automatic cfg_set(input logic [1:0] idx, input logic [15:0] b, input logic [15:0] m,
                           input logic [3:0] ws, input logic en);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_base = b;
        cfg_mask = m;
        cfg_ws   = ws;
        cfg_en   = en;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [15:0] b, input logic [15:0] m,
                             input logic [3:0] ws, input logic en);
        @(posedge clk);
        #1 cfg_set(idx, b, m, ws, en);
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", {28'd0, cs}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        access(16'h0900, 4'b0010, 0);
        access(16'h0500, 4'b0001, 0);
        cfg_write(2'd3, 16'h7C00, 16'hFC00, 4'd3, 1'b1);
        access(16'h7C10, 4'b1000, 3);
        access(16'h2000, 4'b0000, 0);

        // Entry 0 moved onto entry 2's window: lowest index wins.
        cfg_write(2'd0, 16'h0C00, 16'hFC00, 4'd1, 1'b1);
        access(16'h0C00, 4'b0001, 1);
        access(16'h0400, 4'b0000, 0);

        // Disable region 1 while a region-1 access is in flight.
        cfg_write(2'd1, 16'h0800, 16'hFC00, 4'd4, 1'b1);
        @(posedge clk);
        #1 issue(16'h0900, 4'b0010, 4);
        @(posedge clk);
        #1 cfg_set(2'd1, 16'h0800, 16'hFC00, 4'd0, 1'b0);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        wait_done();
        access(16'h0800, 4'b0000, 0);

        // Same-cycle re-enable and request: decode uses the old (disabled) entry.
        @(posedge clk);
        #1 begin
            cfg_set(2'd1, 16'h0800, 16'hFC00, 4'd0, 1'b1);
            issue(16'h0800, 4'b0000, 0);
        end
        @(posedge clk);
        #1 cfg_we = 1'b0;
        wait_done();
        access(16'h0800, 4'b0010, 0);

        // Reset in the middle of a 5-wait-state access.
        cfg_write(2'd3, 16'h7C00, 16'hFC00, 4'd5, 1'b1);
        @(posedge clk);
        #1 begin
            req  = 1'b1;
            addr = 16'h7C00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1 begin
            rst_n = 1'b0;
            req   = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        chk("abort_cs", {28'd0, cs}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);

        access(16'h0400, 4'b0001, 0);
        access(16'h0C00, 4'b0100, 0);
        access(16'h7C10, 4'b1000, 0);

        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
